// File: rtl/rv_wb_pkg.sv
`default_nettype none
// ============================================================================
// rv_wb_pkg : shared types and sizes for the register-file writeback path
// Revision  : 1.0
// ============================================================================
package rv_wb_pkg;

    localparam int XLEN     = 64;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_L = 1'b1
    } wb_port_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : small writeback request FIFO exposing per-entry valid/rd
// Revision : 1.0
// ============================================================================
module wb_fifo import rv_wb_pkg::*; #(
    parameter int  DEPTH = 2,
    parameter int  RD_W  = 5,
    parameter type T     = wb_req_t
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  T                           wr_data,
    output T                           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DEPTH-1:0]           ent_valid,
    output logic [DEPTH-1:0][RD_W-1:0] ent_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Push and pop can only hit the same slot when empty or full, and
    // neither is then allowed, so the valid-bit updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                ent_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                ent_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_rd
        assign ent_rd[i] = mem[i].rd;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter : round-robin merge of ALU and load writebacks onto the
//                      single register-bank write port, with hazard tracking
// Revision           : 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN   = rv_wb_pkg::XLEN,
    parameter int REG_AW = rv_wb_pkg::REG_AW,
    parameter int DEPTH  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            a_valid,
    output logic                            a_ready,
    input  logic [REG_AW-1:0]               a_rd,
    input  logic [XLEN-1:0]                 a_data,
    input  logic                            l_valid,
    output logic                            l_ready,
    input  logic [REG_AW-1:0]               l_rd,
    input  logic [XLEN-1:0]                 l_data,
    output logic                            rf_we,
    output logic [REG_AW-1:0]               rf_waddr,
    output logic [XLEN-1:0]                 rf_wdata,
    output logic [rv_wb_pkg::NUM_REGS-1:0]  pending,
    output logic                            hazard_err,
    output logic                            idle
);
    import rv_wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } req_t;

    req_t                          a_wr, l_wr, a_head, l_head, head;
    logic [CW-1:0]                 a_count, l_count;
    logic                          a_full, l_full, a_empty, l_empty;
    logic                          a_push, l_push, grant_a, grant_l, grant_any;
    logic                          hazard_hit;
    logic [DEPTH-1:0]              a_ent_valid, l_ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0]  a_ent_rd, l_ent_rd;
    logic [NUM_REGS-1:0]           pend;
    wb_port_e                      rr_last;
    logic                          unused_full;

    assign a_wr   = '{rd: a_rd, data: a_data};
    assign l_wr   = '{rd: l_rd, data: l_data};

    assign a_ready = rst_n && !flush && (a_count < CNT_DEPTH);
    assign l_ready = rst_n && !flush && (l_count < CNT_DEPTH);
    assign a_push  = a_valid && a_ready;
    assign l_push  = l_valid && l_ready;
    assign unused_full = a_full ^ l_full;

    wb_fifo #(.DEPTH(DEPTH), .RD_W(REG_AW), .T(req_t)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(a_push), .pop(grant_a && !flush), .wr_data(a_wr), .head(a_head),
        .full(a_full), .empty(a_empty), .count(a_count),
        .ent_valid(a_ent_valid), .ent_rd(a_ent_rd)
    );

    wb_fifo #(.DEPTH(DEPTH), .RD_W(REG_AW), .T(req_t)) u_fifo_l (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(l_push), .pop(grant_l && !flush), .wr_data(l_wr), .head(l_head),
        .full(l_full), .empty(l_empty), .count(l_count),
        .ent_valid(l_ent_valid), .ent_rd(l_ent_rd)
    );

    // Under contention the port that did not win last time gets the grant.
    assign grant_a   = !a_empty && (l_empty || rr_last == PORT_L);
    assign grant_l   = !l_empty && (a_empty || rr_last == PORT_A);
    assign grant_any = grant_a || grant_l;
    assign head      = grant_a ? a_head : l_head;

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ent_valid[i]) pend[a_ent_rd[i]] = 1'b1;
            if (l_ent_valid[i]) pend[l_ent_rd[i]] = 1'b1;
        end
        if (rf_we) pend[rf_waddr] = 1'b1;
        pend[0] = 1'b0;
    end
    assign pending = pend;

    assign hazard_hit = (a_push && a_rd != '0 && pending[a_rd])
                     || (l_push && l_rd != '0 && pending[l_rd])
                     || (a_push && l_push && a_rd == l_rd && a_rd != '0);

    assign idle = a_empty && l_empty && !rf_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rr_last    <= PORT_A;
            hazard_err <= 1'b0;
        end else begin
            if (hazard_hit) hazard_err <= 1'b1;
            if (flush) begin
                rf_we <= 1'b0;
            end else begin
                rf_we <= grant_any && (head.rd != '0);
                if (grant_any) begin
                    rf_waddr <= head.rd;
                    rf_wdata <= head.data;
                end
                if (!a_empty && !l_empty) begin
                    rr_last <= grant_a ? PORT_A : PORT_L;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter : directed table plus queue-model random checking
// Revision              : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        a_valid = 1'b0, l_valid = 1'b0;
    logic        a_ready, l_ready;
    logic [4:0]  a_rd = '0, l_rd = '0;
    logic [63:0] a_data = '0, l_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [31:0] pending;
    logic        hazard_err, idle;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.XLEN(64), .REG_AW(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .hazard_err(hazard_err), .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per source, a sticky hazard flag and the
    // last write presented to the bank.
    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    ent_t        qa[$];
    ent_t        ql[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic        m_last_l;
    logic        m_haz;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic [31:0] e_pend;
        logic        e_idle;
        logic        e_haz;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (qa[i]) p[qa[i].rd] = 1'b1;
        foreach (ql[i]) p[ql[i].rd] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        qa.delete();
        ql.delete();
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_last_l = 1'b0;
        m_haz = 1'b0;
    endtask

    task automatic run_cycle(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                             input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                             input logic fl);
        logic [31:0] pend;
        logic        ra, rl, ga, gl;
        ent_t        h;
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        l_valid = lv; l_rd = lrd; l_data = ld;
        flush = fl;
        #1;
        pend = model_pending();
        ra = (qa.size() < DEPTH) && !fl;
        rl = (ql.size() < DEPTH) && !fl;
        vectors++;
        chk("a_ready", a_ready, ra);
        chk("l_ready", l_ready, rl);
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("pending", pending, pend);
        chk("idle", idle, (qa.size() == 0) && (ql.size() == 0) && !m_we);
        chk("hazard_err", hazard_err, m_haz);
        if (fl) begin
            qa.delete();
            ql.delete();
            m_we = 1'b0;
        end else begin
            ga = 1'b0;
            gl = 1'b0;
            if (qa.size() > 0 && ql.size() > 0) begin
                if (m_last_l) ga = 1'b1; else gl = 1'b1;
                m_last_l = gl;
            end else if (qa.size() > 0) begin
                ga = 1'b1;
            end else if (ql.size() > 0) begin
                gl = 1'b1;
            end
            if (ga || gl) begin
                h = ga ? qa.pop_front() : ql.pop_front();
                m_we = (h.rd != 0);
                m_addr = h.rd;
                m_data = h.data;
            end else begin
                m_we = 1'b0;
            end
            if (av && ra) begin
                if (ard != 0 && pend[ard]) m_haz = 1'b1;
                qa.push_back('{rd: ard, data: ad});
            end
            if (lv && rl) begin
                if (lrd != 0 && pend[lrd]) m_haz = 1'b1;
                ql.push_back('{rd: lrd, data: ld});
            end
            if (av && ra && lv && rl && ard == lrd && ard != 0) m_haz = 1'b1;
        end
    endtask

    // Asserted mid-cycle: every output must clear without waiting for a clock.
    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_waddr", rf_waddr, 5'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_pending", pending, 32'd0);
        chk("rst_hazard", hazard_err, 1'b0);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_l_ready", l_ready, 1'b0);
        chk("rst_idle", idle, 1'b1);
        model_reset();
        a_valid = 1'b0; l_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    32'h0,  1'b1, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,    32'h20, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b1, 5'd5, 64'hDEAD, 32'h20, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd0, 64'h1234, 1'b0, 5'd0, 64'h0,  1'b0, 5'd5, 64'hDEAD, 32'h0,  1'b1, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b0, 5'd5, 64'hDEAD, 32'h0,  1'b0, 1'b0};
        tbl[5] = '{1'b1, 5'd7, 64'h77,   1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h1234, 32'h0,  1'b1, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd7, 64'h88, 1'b0, 5'd0, 64'h1234, 32'h80, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 64'h77,   32'h80, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b1, 5'd7, 64'h88,   32'h80, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0, 64'h0,  1'b0, 5'd7, 64'h88,   32'h0,  1'b1, 1'b1};

        model_reset();
        pulse_reset();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
            l_valid = tbl[i].lv; l_rd = tbl[i].lrd; l_data = tbl[i].ld;
            flush = 1'b0;
            #1;
            vectors++;
            chk($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_waddr", i), rf_waddr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_data);
            chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
            chk($sformatf("tbl%0d_idle", i), idle, tbl[i].e_idle);
            chk($sformatf("tbl%0d_hazard", i), hazard_err, tbl[i].e_haz);
            chk($sformatf("tbl%0d_a_ready", i), a_ready, 1'b1);
            chk($sformatf("tbl%0d_l_ready", i), l_ready, 1'b1);
        end

        pulse_reset();

        // Both sources push every cycle: alternating grants, FIFOs back up.
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 5'(2 + i), 64'(100 + i), 1'b1, 5'(16 + i), 64'(200 + i), 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        end

        // Fill, then flush with pushes presented in the flush cycle.
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 5'(3 + i), 64'(300 + i), 1'b1, 5'(20 + i), 64'(400 + i), 1'b0);
        end
        run_cycle(1'b1, 5'd9, 64'h999, 1'b1, 5'd10, 64'hAAA, 1'b1);
        run_cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        vectors++;
        chk("flush_idle", idle, 1'b1);
        chk("flush_pending", pending, 32'd0);

        // Refill and reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1, 5'(11 + i), 64'(500 + i), 1'b1, 5'(25 + i), 64'(600 + i), 1'b0);
        end
        pulse_reset();

        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                      5'($urandom_range(0, 31)), {$urandom, $urandom},
                      ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                      5'($urandom_range(0, 31)), {$urandom, $urandom},
                      ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
